// File: rtl/hc165_serializer.sv
// hc165_serializer: 74HC165-style 8-bit PISO shifter with start/busy/done framing.
// Define HC165_PARITY_EN to append an even-parity bit after D[0].
module hc165_serializer (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_d,
    input  logic       i_ds,
    input  logic       i_inh,
    output logic       o_q7,
    output logic       o_qn7,
    output logic       o_busy,
    output logic       o_done
);
`ifdef HC165_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
    state_t     r_state;
    logic [7:0] r_shreg;
    logic [2:0] r_cnt;
`ifdef HC165_PARITY_EN
    logic       r_par;
`endif
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_shreg <= 8'd0;
            r_cnt   <= 3'd0;
`ifdef HC165_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                // DONE accepts a new frame exactly like IDLE so frames can run back-to-back
                IDLE, DONE: begin
                    if (i_start) begin
                        r_shreg <= i_d;
                        r_cnt   <= 3'd0;
`ifdef HC165_PARITY_EN
                        r_par   <= ^i_d;
`endif
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (!i_inh) begin
                        r_shreg <= {r_shreg[6:0], i_ds};
                        r_cnt   <= (r_cnt == 3'd7) ? r_cnt : r_cnt + 3'd1;
`ifdef HC165_PARITY_EN
                        r_state <= (r_cnt == 3'd7) ? PAR : SHIFT;
`else
                        r_state <= (r_cnt == 3'd7) ? DONE : SHIFT;
`endif
                    end
                end
`ifdef HC165_PARITY_EN
                PAR: r_state <= i_inh ? PAR : DONE;
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
`ifdef HC165_PARITY_EN
    assign o_q7   = (r_state == PAR) ? r_par : r_shreg[7];
    assign o_busy = (r_state == SHIFT) || (r_state == PAR);
`else
    assign o_q7   = r_shreg[7];
    assign o_busy = (r_state == SHIFT);
`endif
    assign o_qn7  = ~o_q7;
    assign o_done = (r_state == DONE);
endmodule

// File: tb/tb_hc165_serializer.sv
// tb_hc165_serializer: directed scoreboard bench for hc165_serializer.
// Expected {q7,qn7,busy,done} per cycle are queued as stimulus is driven.
module tb_hc165_serializer;
    logic       clk = 1'b0;
    logic       rst, start, ds, inh;
    logic [7:0] d;
    logic       q7, qn7, busy, done;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];

    hc165_serializer dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_d(d), .i_ds(ds), .i_inh(inh),
        .o_q7(q7), .o_qn7(qn7), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ev(input logic q, input logic b, input logic dn);
        return {q, ~q, b, dn};
    endfunction

    task automatic cyc(input string tag);
        logic [3:0] e;
        logic [3:0] obs;
        @(posedge clk);
        @(negedge clk);
        obs = {q7, qn7, busy, done};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty observed=%b", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed{q7,qn7,busy,done}=%b expected=%b", tag, obs, e);
            end
        end
    endtask

    task automatic shift(input logic [7:0] v, input int lo, input int hi, input string tag);
        for (int k = lo; k <= hi; k++) begin
            exp_q.push_back(ev(v[7-k], 1'b1, 1'b0));
            cyc($sformatf("%s_bit%0d", tag, k));
        end
    endtask

    task automatic tail(input logic [7:0] v, input logic s, input string tag);
`ifdef HC165_PARITY_EN
        exp_q.push_back(ev(^v, 1'b1, 1'b0));
        cyc({tag, "_par"});
`endif
        exp_q.push_back(ev(s, 1'b0, 1'b1));
        cyc({tag, "_done"});
    endtask

    task automatic send(input logic [7:0] v, input logic s, input string tag);
        ds = s; d = v; start = 1'b1;
        exp_q.push_back(ev(v[7], 1'b1, 1'b0));
        cyc({tag, "_load"});
        start = 1'b0;
        shift(v, 1, 7, tag);
        tail(v, s, tag);
        exp_q.push_back(ev(s, 1'b0, 1'b0));
        cyc({tag, "_idle"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b1; d = 8'hFF; ds = 1'b0; inh = 1'b0;
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0)); cyc("rst0");
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0)); cyc("rst1");
        rst = 1'b0; start = 1'b0;
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0)); cyc("rst_idle");

        send(8'hA5, 1'b0, "basic");
        send(8'h01, 1'b1, "cascade");

        // inhibit held for two shift edges after D[5] appears
        d = 8'hA5; ds = 1'b0; start = 1'b1;
        exp_q.push_back(ev(1'b1, 1'b1, 1'b0)); cyc("inh_load");
        start = 1'b0;
        shift(8'hA5, 1, 2, "inh");
        inh = 1'b1;
        exp_q.push_back(ev(1'b1, 1'b1, 1'b0)); cyc("inh_hold0");
        exp_q.push_back(ev(1'b1, 1'b1, 1'b0)); cyc("inh_hold1");
        inh = 1'b0;
        shift(8'hA5, 3, 7, "inh");
        tail(8'hA5, 1'b0, "inh");

        // Inh asserted while idle must not block the load
        inh = 1'b1; d = 8'hC3; start = 1'b1;
        exp_q.push_back(ev(1'b1, 1'b1, 1'b0)); cyc("inh_idle_load");
        start = 1'b0;
        exp_q.push_back(ev(1'b1, 1'b1, 1'b0)); cyc("inh_idle_hold");
        inh = 1'b0;
        shift(8'hC3, 1, 7, "inh_idle");
        tail(8'hC3, 1'b0, "inh_idle");

        // collision start mid-frame, then back-to-back frame with Start held
        d = 8'hA5; start = 1'b1;
        exp_q.push_back(ev(1'b1, 1'b1, 1'b0)); cyc("col_load");
        start = 1'b0;
        shift(8'hA5, 1, 2, "col");
        start = 1'b1; d = 8'h00;
        shift(8'hA5, 3, 3, "col");
        start = 1'b0;
        shift(8'hA5, 4, 7, "col");
        start = 1'b1; d = 8'h3C;
        tail(8'hA5, 1'b0, "col");
        exp_q.push_back(ev(1'b0, 1'b1, 1'b0)); cyc("b2b_load");
        start = 1'b0;
        shift(8'h3C, 1, 7, "b2b");
        tail(8'h3C, 1'b0, "b2b");
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0)); cyc("b2b_idle");

        // mid-frame reset aborts the frame without a Done pulse
        d = 8'hA5; ds = 1'b1; start = 1'b1;
        exp_q.push_back(ev(1'b1, 1'b1, 1'b0)); cyc("mrst_load");
        start = 1'b0;
        shift(8'hA5, 1, 3, "mrst");
        rst = 1'b1;
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0)); cyc("mrst_rst");
        rst = 1'b0;
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0)); cyc("mrst_idle0");
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0)); cyc("mrst_idle1");
        send(8'h5A, 1'b1, "post_rst");

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL leftover observed=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
